// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receive path: frame states, supported
// oversampling ratios and parity type encoding.
package uart_rx_pkg;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   localparam logic [5:0] PRESCALE_8  = 6'd8;
   localparam logic [5:0] PRESCALE_16 = 6'd16;
   localparam logic [5:0] PRESCALE_32 = 6'd32;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // Unsupported ratios fall back to 8 so the edge counter always wraps sanely.
   function automatic logic [5:0] sanitize_prescale(input logic [5:0] p);
      case (p)
         PRESCALE_16, PRESCALE_32: return p;
         default:                  return PRESCALE_8;
      endcase
   endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter (wraps at prescale-1) and received-bit counter.
// bit_done marks the last edge of each bit period, i.e. the decision point.
module uart_rx_edge_bit_cnt #(
   parameter int BIT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             bit_en,
   input  logic [5:0]       prescale,
   output logic [5:0]       edge_count,
   output logic [BIT_W-1:0] bit_count,
   output logic             bit_done
);

   assign bit_done = en && (edge_count == prescale - 6'd1);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         edge_count <= '0;
         bit_count  <= '0;
      end else if (en) begin
         if (bit_done) begin
            edge_count <= '0;
            if (bit_en) bit_count <= bit_count + 1'b1;
         end else begin
            edge_count <= edge_count + 6'd1;
         end
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detection, LSB-first deserialization,
// parity/stop checking and one-cycle result pulses.
module uart_rx_ctrl
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  RX_in,
   input  logic [5:0]            prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  sampled_bit,
   output logic                  data_sampling_en,
   output logic [5:0]            edge_count,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  parity_error,
   output logic                  stop_error,
   output logic                  busy
);

   localparam int BIT_W = $clog2(DATA_WIDTH + 1);

   logic [2:0]            state;
   logic [5:0]            p_lat;
   logic                  par_en_l;
   logic                  par_typ_l;
   logic [DATA_WIDTH-1:0] shreg;
   logic [BIT_W-1:0]      bit_count;
   logic                  bit_done;
   logic                  in_frame;
   logic                  last_bit;
   logic                  par_exp;

   assign in_frame         = (state != IDLE);
   assign busy             = in_frame;
   assign data_sampling_en = in_frame;
   assign last_bit         = (bit_count == BIT_W'(DATA_WIDTH - 1));
   assign par_exp          = (^shreg) ^ (par_typ_l == PAR_ODD);

   uart_rx_edge_bit_cnt #(.BIT_W(BIT_W)) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .en         (in_frame),
      .clr        (state == IDLE),
      .bit_en     (state == DATA),
      .prescale   (p_lat),
      .edge_count (edge_count),
      .bit_count  (bit_count),
      .bit_done   (bit_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         p_lat        <= PRESCALE_8;
         par_en_l     <= 1'b0;
         par_typ_l    <= PAR_EVEN;
         shreg        <= '0;
         P_DATA       <= '0;
         data_valid   <= 1'b0;
         parity_error <= 1'b0;
         stop_error   <= 1'b0;
      end else begin
         data_valid   <= 1'b0;
         parity_error <= 1'b0;
         stop_error   <= 1'b0;
         case (state)
            IDLE: begin
               // Config is frozen for the whole frame at start detection.
               if (!RX_in) begin
                  state     <= START;
                  p_lat     <= sanitize_prescale(prescale);
                  par_en_l  <= PAR_EN;
                  par_typ_l <= PAR_TYP;
               end
            end
            START: begin
               if (bit_done) state <= sampled_bit ? IDLE : DATA;
            end
            DATA: begin
               if (bit_done) begin
                  shreg <= {sampled_bit, shreg[DATA_WIDTH-1:1]};
                  if (last_bit) state <= par_en_l ? PARITY : STOP;
               end
            end
            PARITY: begin
               if (bit_done) begin
                  if (sampled_bit != par_exp) begin
                     parity_error <= 1'b1;
                     state        <= IDLE;
                  end else begin
                     state <= STOP;
                  end
               end
            end
            STOP: begin
               if (bit_done) begin
                  state <= IDLE;
                  if (sampled_bit) begin
                     P_DATA     <= shreg;
                     data_valid <= 1'b1;
                  end else begin
                     stop_error <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed + randomized frame bench; a behavioural 3-sample sampler feeds
// sampled_bit and expected results come from a frame-level outcome model.
module tb_uart_rx_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       RX_in = 1'b1;
   logic [5:0] prescale = 6'd8;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic       sampled_bit = 1'b1;
   logic       data_sampling_en;
   logic [5:0] edge_count;
   logic [7:0] P_DATA;
   logic       data_valid, parity_error, stop_error, busy;

   uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .RX_in(RX_in), .prescale(prescale),
      .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .sampled_bit(sampled_bit),
      .data_sampling_en(data_sampling_en), .edge_count(edge_count),
      .P_DATA(P_DATA), .data_valid(data_valid), .parity_error(parity_error),
      .stop_error(stop_error), .busy(busy)
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0;

   // Behavioural sampler: majority of RX_in at P/2-1, P/2, P/2+1, registered.
   int   samp_p = 8;
   logic s0 = 1'b1, s1 = 1'b1;
   always @(posedge clk) begin
      if (rst) begin
         sampled_bit <= 1'b1;
      end else if (data_sampling_en) begin
         if (int'(edge_count) == samp_p/2 - 1) s0 <= RX_in;
         if (int'(edge_count) == samp_p/2)     s1 <= RX_in;
         if (int'(edge_count) == samp_p/2 + 1)
            sampled_bit <= (s0 & s1) | (s0 & RX_in) | (s1 & RX_in);
      end
   end

   // Pulse/busy monitor sampled on the falling edge.
   int   cyc = 0, nv = 0, np = 0, ns = 0, nmulti = 0, nbusy = 0, t_rise = 0, t_pulse = 0;
   logic busy_q = 1'b0;
   always @(negedge clk) begin
      cyc++;
      if (data_valid)   begin nv++; t_pulse = cyc; end
      if (parity_error) begin np++; t_pulse = cyc; end
      if (stop_error)   begin ns++; t_pulse = cyc; end
      if (int'(data_valid) + int'(parity_error) + int'(stop_error) > 1) nmulti++;
      if (busy) nbusy++;
      if (busy && !busy_q) t_rise = cyc;
      busy_q = busy;
   end

   int         b_v, b_p, b_s, b_busy;
   logic [7:0] exp_pd = 8'h00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic snap();
      b_v = nv; b_p = np; b_s = ns; b_busy = nbusy;
   endtask

   function automatic int eff_p(input int p);
      return (p == 16 || p == 32) ? p : 8;
   endfunction

   task automatic drive_bit(input logic b, input int p);
      RX_in = b;
      tick(p);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                             input logic pflip, input logic stopb, input int pport,
                             input logic chg, input logic gap);
      int p;
      p = eff_p(pport);
      samp_p = p;
      prescale = 6'(pport);
      PAR_EN = pen;
      PAR_TYP = ptyp;
      drive_bit(1'b0, p);
      if (chg) begin
         prescale = 6'd8;
         PAR_EN = ~pen;
         PAR_TYP = ~ptyp;
      end
      for (int i = 0; i < 8; i++) drive_bit(d[i], p);
      if (pen) drive_bit((^d) ^ ptyp ^ pflip, p);
      drive_bit(stopb, p);
      RX_in = 1'b1;
      if (gap) tick(2*p + 4);
   endtask

   // Frame outcome: parity checked first (stop ignored on parity error).
   task automatic check_frame(input string tag, input logic [7:0] d, input logic pen,
                              input logic pflip, input logic stopb, input int pport);
      int ev, ep, es;
      ev = 0; ep = 0; es = 0;
      if (pen && pflip)  ep = 1;
      else if (!stopb)   es = 1;
      else begin ev = 1; exp_pd = d; end
      check({tag, ".valid"},  32'(nv - b_v), 32'(ev));
      check({tag, ".perr"},   32'(np - b_p), 32'(ep));
      check({tag, ".serr"},   32'(ns - b_s), 32'(es));
      check({tag, ".pdata"},  32'(P_DATA), 32'(exp_pd));
      if (ev + ep + es == 1 && ep == 0)
         check({tag, ".lat"}, 32'(t_pulse - t_rise), 32'((10 + int'(pen)) * eff_p(pport)));
   endtask

   int         ptab[4] = '{8, 16, 32, 12};
   logic [7:0] rd;
   logic       rpen, rtyp, rflip, rstop;
   int         rp;

   initial begin
      tick(3);
      check("rst.busy",  32'(busy), 32'd0);
      check("rst.en",    32'(data_sampling_en), 32'd0);
      check("rst.edge",  32'(edge_count), 32'd0);
      check("rst.pdata", 32'(P_DATA), 32'd0);
      check("rst.pulse", 32'({data_valid, parity_error, stop_error}), 32'd0);
      rst = 1'b0;
      tick(4);

      snap(); send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 8, 1'b0, 1'b1);
      check_frame("p8_even_A5", 8'hA5, 1'b1, 1'b0, 1'b1, 8);

      snap(); send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 16, 1'b1, 1'b1);
      check_frame("p16_midchg_3C", 8'h3C, 1'b0, 1'b0, 1'b1, 16);

      // Start glitch: low for only two cycles.
      samp_p = 8; prescale = 6'd8;
      snap(); RX_in = 1'b0; tick(2); RX_in = 1'b1; tick(20);
      check("glitch.busy_cycles", 32'(nbusy - b_busy), 32'd8);
      check("glitch.pulses", 32'((nv - b_v) + (np - b_p) + (ns - b_s)), 32'd0);
      check("glitch.pdata", 32'(P_DATA), 32'(exp_pd));

      snap(); send_frame(8'h0F, 1'b1, 1'b1, 1'b1, 1'b1, 8, 1'b0, 1'b1);
      check_frame("p8_odd_bad_0F", 8'h0F, 1'b1, 1'b1, 1'b1, 8);

      // Stop error, then a frame starting right after the bad stop bit.
      snap();
      send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0);
      send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 8, 1'b0, 1'b1);
      exp_pd = 8'h81;
      check("b2b.serr",  32'(ns - b_s), 32'd1);
      check("b2b.valid", 32'(nv - b_v), 32'd1);
      check("b2b.perr",  32'(np - b_p), 32'd0);
      check("b2b.pdata", 32'(P_DATA), 32'h81);

      snap(); send_frame(8'h96, 1'b1, 1'b1, 1'b0, 1'b1, 12, 1'b0, 1'b1);
      check_frame("p12_as_8_96", 8'h96, 1'b1, 1'b0, 1'b1, 12);

      // Reset in the middle of data bit 4.
      samp_p = 8; prescale = 6'd8; PAR_EN = 1'b0;
      snap();
      drive_bit(1'b0, 8);
      for (int i = 0; i < 4; i++) drive_bit(1'b1, 8);
      RX_in = 1'b1; tick(4);
      rst = 1'b1; tick(1); rst = 1'b0;
      exp_pd = 8'h00;
      check("midrst.busy",  32'(busy), 32'd0);
      check("midrst.en",    32'(data_sampling_en), 32'd0);
      check("midrst.edge",  32'(edge_count), 32'd0);
      check("midrst.pdata", 32'(P_DATA), 32'd0);
      check("midrst.pulse", 32'({data_valid, parity_error, stop_error}), 32'd0);
      tick(20);
      check("midrst.none", 32'((nv - b_v) + (np - b_p) + (ns - b_s)), 32'd0);
      snap(); send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 8, 1'b0, 1'b1);
      check_frame("after_rst_FF", 8'hFF, 1'b0, 1'b0, 1'b1, 8);

      for (int k = 0; k < 12; k++) begin
         rd    = 8'($urandom);
         rpen  = 1'($urandom_range(0, 1));
         rtyp  = 1'($urandom_range(0, 1));
         rflip = ($urandom_range(0, 3) == 0);
         rstop = ($urandom_range(0, 3) != 0);
         rp    = ptab[$urandom_range(0, 3)];
         snap(); send_frame(rd, rpen, rtyp, rflip, rstop, rp, 1'b0, 1'b1);
         check_frame($sformatf("rand%0d", k), rd, rpen, rflip, rstop, rp);
      end

      check("pulses_exclusive", 32'(nmulti), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
